stream_checker: RTL and testbench

Consumer end of the generator stream carried over `intf_if`. Accepts `W`-bit beats on a valid/ready handshake, checks each against an internally generated incrementing reference sequence, and reports beat count, error count, first-error capture and pass/fail. Used in elaboration/simulation testcases as the receiving counterpart of the generator.

---
 rtl/stream_checker.sv | 99 +++++++++
 tb/tb_stream_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/stream_checker.sv
// Receiving end of the incrementing-sequence stream: checks each accepted beat
// against a local reference and reports counts, first-error capture and pass/fail.
module stream_checker #(
  parameter int W            = 8,
  parameter int SEED         = 0,
  parameter int COUNT        = 16,
  parameter int STALL_PERIOD = 4,
  parameter int ERR_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      beat_count,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      first_err_idx,
  output logic [W-1:0]     first_err_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [SC_W-1:0]  STALL_LAST = SC_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
  localparam logic [15:0]      LAST_BEAT  = 16'(COUNT - 1);
  localparam logic [W-1:0]     SEED_W     = W'(SEED);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  state_t          state, state_next;
  logic [SC_W-1:0] stall_cnt;
  logic [W-1:0]    expected;
  logic            launch, stall, accept, last_accept, mismatch;

  assign launch      = start && (state == IDLE || state == DONE);
  assign stall       = (STALL_PERIOD != 0) && (stall_cnt == STALL_LAST);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (beat_count == LAST_BEAT);
  assign mismatch    = in_data != expected;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_accept) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // in_ready comes only from registered state and the stall counter
  always_comb begin
    in_ready = (state == RUN) && !stall;
    busy     = (state == RUN);
    done     = (state == DONE);
    pass     = (state == DONE) && (err_count == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt      <= '0;
      expected       <= SEED_W;
      beat_count     <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else if (launch) begin
      stall_cnt      <= '0;
      expected       <= SEED_W;
      beat_count     <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else if (state == RUN) begin
      if (last_accept || STALL_PERIOD == 0 || stall) stall_cnt <= '0;
      else                                            stall_cnt <= stall_cnt + SC_W'(1);
      if (accept) begin
        expected   <= expected + W'(1);
        beat_count <= beat_count + 16'd1;
        if (mismatch) begin
          if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
          if (err_count == '0) begin
            first_err_idx  <= beat_count;
            first_err_data <= in_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: three configurations (default, wrapping
// seed, narrow saturating error counter) with a scoreboard of run results.
module tb_stream_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_s    [3];
  logic        in_valid_s [3];
  logic [7:0]  in_data_s  [3];
  logic        in_ready_s [3];
  logic        busy_s     [3];
  logic        done_s     [3];
  logic        pass_s     [3];
  logic [15:0] beat_s     [3];
  logic [7:0]  err_s      [3];
  logic [15:0] fidx_s     [3];
  logic [7:0]  fdata_s    [3];
  logic [1:0]  err_c;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int errs;
    int fidx;
    int fdata;
    int pass;
  } result_t;
  result_t sb[$];

  always #5 clk = ~clk;

  stream_checker #(.W(8), .SEED(0), .COUNT(16), .STALL_PERIOD(4), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .in_valid(in_valid_s[0]), .in_data(in_data_s[0]),
    .in_ready(in_ready_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .beat_count(beat_s[0]), .err_count(err_s[0]), .first_err_idx(fidx_s[0]),
    .first_err_data(fdata_s[0]));

  stream_checker #(.W(8), .SEED(8'hFE), .COUNT(4), .STALL_PERIOD(4), .ERR_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .in_valid(in_valid_s[1]), .in_data(in_data_s[1]),
    .in_ready(in_ready_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .beat_count(beat_s[1]), .err_count(err_s[1]), .first_err_idx(fidx_s[1]),
    .first_err_data(fdata_s[1]));

  stream_checker #(.W(8), .SEED(0), .COUNT(8), .STALL_PERIOD(4), .ERR_W(2)) dut_c (
    .clk(clk), .rst(rst), .start(start_s[2]), .in_valid(in_valid_s[2]), .in_data(in_data_s[2]),
    .in_ready(in_ready_s[2]), .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
    .beat_count(beat_s[2]), .err_count(err_c), .first_err_idx(fidx_s[2]),
    .first_err_data(fdata_s[2]));

  assign err_s[2] = {6'b0, err_c};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_ready", 32'(in_ready_s[d]), 0);
    check("rst_busy",  32'(busy_s[d]), 0);
    check("rst_done",  32'(done_s[d]), 0);
    check("rst_pass",  32'(pass_s[d]), 0);
    check("rst_beats", 32'(beat_s[d]), 0);
    check("rst_errs",  32'(err_s[d]), 0);
    check("rst_fidx",  32'(fidx_s[d]), 0);
    check("rst_fdata", 32'(fdata_s[d]), 0);
  endtask

  // Reference result of a complete run, built independently of the DUT.
  function automatic result_t model(input logic [7:0] seed, input int errmax,
                                    input logic [7:0] vals[$]);
    result_t r;
    logic [7:0] exp_v;
    r = '{errs: 0, fidx: 0, fdata: 0, pass: 0};
    exp_v = seed;
    foreach (vals[i]) begin
      if (vals[i] != exp_v) begin
        if (r.errs == 0) begin
          r.fidx  = i;
          r.fdata = int'(vals[i]);
        end
        if (r.errs < errmax) r.errs++;
      end
      exp_v = exp_v + 8'd1;
    end
    r.pass = (r.errs == 0) ? 1 : 0;
    return r;
  endfunction

  // One run on DUT d. abort_at >= 0 pulses rst once that many beats are accepted.
  task automatic do_run(input int d, input logic [7:0] seed, input int errmax,
                        input logic [7:0] vals[$], input bit gaps, input bit mid_start,
                        input int exp_done_cyc, input bit check_stalls, input int abort_at);
    int cyc = 1;
    int idx = 0;
    bit acc;
    int low[$];
    result_t r;
    if (abort_at < 0) sb.push_back(model(seed, errmax, vals));
    start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    while (cyc < 200) begin
      if (done_s[d]) break;
      check("beat_count_track", 32'(beat_s[d]), 32'(idx));
      if (abort_at >= 0 && idx == abort_at) begin
        in_valid_s[d] = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs(d);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (!in_ready_s[d]) low.push_back(cyc);
      in_valid_s[d] = !(gaps && (cyc % 5 == 2)) && (idx < vals.size());
      in_data_s[d]  = (idx < vals.size()) ? vals[idx] : 8'h00;
      start_s[d]    = mid_start && (cyc == 6);
      acc = in_valid_s[d] && in_ready_s[d];
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid_s[d] = 1'b0;
    start_s[d]    = 1'b0;
    check("run_finished", 32'(done_s[d]), 1);
    if (!done_s[d]) return;
    if (exp_done_cyc > 0) check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
    if (check_stalls) begin
      check("stall_count", 32'(low.size()), 5);
      foreach (low[k]) check("stall_cycle", 32'(low[k]), 32'(4 * (k + 1)));
    end
    check("done_ready", 32'(in_ready_s[d]), 0);
    check("done_busy",  32'(busy_s[d]), 0);
    r = sb.pop_front();
    check("beat_count", 32'(beat_s[d]), 32'(vals.size()));
    check("err_count",  32'(err_s[d]), 32'(r.errs));
    check("pass",       32'(pass_s[d]), 32'(r.pass));
    if (r.errs != 0) begin
      check("first_err_idx",  32'(fidx_s[d]), 32'(r.fidx));
      check("first_err_data", 32'(fdata_s[d]), 32'(r.fdata));
    end
    repeat (2) @(posedge clk);
    #1;
    check("done_held", 32'(done_s[d]), 1);
  endtask

  initial begin
    logic [7:0] clean[$];
    logic [7:0] bad[$];
    logic [7:0] wrap_ok[$];
    logic [7:0] wrap_bad[$];
    logic [7:0] all_bad[$];
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      in_valid_s[i] = 1'b0;
      in_data_s[i] = 8'h00;
    end
    for (int i = 0; i < 16; i++) clean.push_back(8'(i));
    bad = clean;
    bad[5] = 8'h55;
    bad[9] = 8'h00;
    wrap_ok  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    wrap_bad = '{8'hFE, 8'hFF, 8'h02, 8'h01};
    for (int i = 0; i < 8; i++) all_bad.push_back(8'(8'hA0 + i));

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", 32'(in_ready_s[0]), 0);

    do_run(0, 8'h00, 255, clean, 1'b0, 1'b0, 22, 1'b1, -1);
    do_run(0, 8'h00, 255, bad,   1'b0, 1'b0, 22, 1'b0, -1);
    do_run(0, 8'h00, 255, clean, 1'b1, 1'b1, -1, 1'b0, -1);
    do_run(0, 8'h00, 255, clean, 1'b0, 1'b0, 22, 1'b0, -1);
    do_run(0, 8'h00, 255, clean, 1'b0, 1'b0, -1, 1'b0, 8);
    do_run(0, 8'h00, 255, clean, 1'b0, 1'b0, 22, 1'b0, -1);

    do_run(1, 8'hFE, 255, wrap_ok,  1'b0, 1'b0, -1, 1'b0, -1);
    do_run(1, 8'hFE, 255, wrap_bad, 1'b0, 1'b0, -1, 1'b0, -1);

    do_run(2, 8'h00, 3, all_bad, 1'b0, 1'b0, -1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
